board_ram_arbiter: RTL and testbench

Shares the single-port 10x10 Othello board RAM (100 cells, 2 bits each: 00 empty, 01 black, 10 white, 11 border) between three requesters: the board initializer, the game-logic engine (move check / flip), and the display scanner. Owner selection is a registered state machine with fixed priority init > logic > display. Logic bursts are capped so the display is never starved. Read data is returned one cycle after the access, tagged to whichever requester issued it.

---
 rtl/board_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_board_ram_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Shares the single-port 10x10 Othello board RAM (2 bits per cell) between
//   the board initializer, the game-logic engine and the display scanner.
//   Ownership is a registered one-hot state with fixed priority
//   init > logic > display. Logic bursts are capped at MAX_BURST cycles while
//   the display is waiting. Read data returns one cycle after the access and
//   is steered to the requester that issued it.
//
// Ports
//   clock, reset        system clock, synchronous active-low reset
//   init_*              initializer request/address/data/wren, grant
//   logic_*             logic request/address/wdata/wren, grant, read return
//   disp_*              display request/address (read-only), grant, read return
//   ram_addr/data/wren  RAM port driven by the current owner
//   ram_q               RAM read data, valid one cycle after ram_addr
module board_ram_arbiter #(
  parameter int unsigned CELLS     = 100,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init_req,
  input  logic [6:0] init_addr,
  input  logic [1:0] init_data,
  input  logic       init_wren,
  output logic       init_gnt,
  input  logic       logic_req,
  input  logic [6:0] logic_addr,
  input  logic [1:0] logic_wdata,
  input  logic       logic_wren,
  output logic       logic_gnt,
  output logic       logic_rvalid,
  output logic [1:0] logic_rdata,
  input  logic       disp_req,
  input  logic [6:0] disp_addr,
  output logic       disp_gnt,
  output logic       disp_rvalid,
  output logic [1:0] disp_rdata,
  output logic [6:0] ram_addr,
  output logic [1:0] ram_data,
  output logic       ram_wren,
  input  logic [1:0] ram_q
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_INIT  = 4'b0010,
    ST_LOGIC = 4'b0100,
    ST_DISP  = 4'b1000
  } state_t;

  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [7:0]    ADDR_LIMIT = 8'(CELLS);

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;

  // Next owner
  always_comb begin
    state_d = ST_IDLE;
    if (init_req) begin
      state_d = ST_INIT;
    end else if (state_q == ST_LOGIC && logic_req &&
                 (burst_q < BURST_LAST || !disp_req)) begin
      state_d = ST_LOGIC;
    end else if (state_q == ST_LOGIC && disp_req) begin
      // burst exhausted with display waiting: hand over for one turn
      state_d = ST_DISP;
    end else if (logic_req) begin
      state_d = ST_LOGIC;
    end else if (disp_req) begin
      state_d = ST_DISP;
    end
  end

  // Burst counter: cleared on entry to LOGIC, counts LOGIC cycles, saturates
  always_comb begin
    burst_d = burst_q;
    if (state_d == ST_LOGIC) begin
      if (state_q != ST_LOGIC) begin
        burst_d = '0;
      end else if (burst_q != '1) begin
        burst_d = burst_q + 1'b1;
      end
    end
  end

  assign init_gnt  = state_q[1];
  assign logic_gnt = state_q[2];
  assign disp_gnt  = state_q[3];

  // Port mux from the owner state
  logic       own_req;
  logic       own_wren;
  logic [6:0] mux_addr;
  logic [1:0] mux_data;

  always_comb begin
    own_req  = 1'b0;
    own_wren = 1'b0;
    mux_addr = '0;
    mux_data = '0;
    unique case (state_q)
      ST_INIT: begin
        own_req  = init_req;
        own_wren = init_wren;
        mux_addr = init_addr;
        mux_data = init_data;
      end
      ST_LOGIC: begin
        own_req  = logic_req;
        own_wren = logic_wren;
        mux_addr = logic_addr;
        mux_data = logic_wdata;
      end
      ST_DISP: begin
        own_req  = disp_req;
        mux_addr = disp_addr;
      end
      default: begin
        own_req = 1'b0;
      end
    endcase
  end

  logic in_range;
  logic rd_logic, rd_disp;

  assign in_range = {1'b0, mux_addr} < ADDR_LIMIT;
  assign ram_addr = mux_addr;
  assign ram_data = mux_data;
  assign ram_wren = own_req & own_wren & in_range;
  // A write request to an out-of-range cell is still a write: no read return
  assign rd_logic = own_req & ~own_wren & (state_q == ST_LOGIC);
  assign rd_disp  = own_req & (state_q == ST_DISP);

  // Read return pipeline
  logic       lpend_q, dpend_q, oor_q;
  logic [1:0] lhold_q, dhold_q;
  logic [1:0] rdata_now;

  assign rdata_now = oor_q ? 2'b11 : ram_q;
  // A read still in flight when reset is asserted is dropped immediately
  assign logic_rvalid = lpend_q & reset;
  assign disp_rvalid  = dpend_q & reset;
  assign logic_rdata  = logic_rvalid ? rdata_now : lhold_q;
  assign disp_rdata   = disp_rvalid  ? rdata_now : dhold_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      lpend_q <= 1'b0;
      dpend_q <= 1'b0;
      oor_q   <= 1'b0;
      lhold_q <= '0;
      dhold_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      lpend_q <= rd_logic;
      dpend_q <= rd_disp;
      oor_q   <= ~in_range;
      if (logic_rvalid) lhold_q <= rdata_now;
      if (disp_rvalid)  dhold_q <= rdata_now;
    end
  end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter
//   Directed bench for board_ram_arbiter with a behavioural board RAM.
//   Expected read returns are queued when the read is issued; a monitor pops
//   and compares whenever logic_rvalid or disp_rvalid is seen.
module tb_board_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       init_req, init_wren, logic_req, logic_wren, disp_req;
  logic [6:0] init_addr, logic_addr, disp_addr;
  logic [1:0] init_data, logic_wdata;
  logic       init_gnt, logic_gnt, disp_gnt, logic_rvalid, disp_rvalid;
  logic [1:0] logic_rdata, disp_rdata;
  logic [6:0] ram_addr;
  logic [1:0] ram_data, ram_q;
  logic       ram_wren;

  logic [1:0] mem [0:127] = '{default: 2'b00};

  int tests = 0;
  int fails = 0;
  logic [1:0] lq[$];
  logic [1:0] dq[$];

  board_ram_arbiter #(.CELLS(100), .MAX_BURST(16)) dut (
    .clock(clock), .reset(reset),
    .init_req(init_req), .init_addr(init_addr), .init_data(init_data),
    .init_wren(init_wren), .init_gnt(init_gnt),
    .logic_req(logic_req), .logic_addr(logic_addr), .logic_wdata(logic_wdata),
    .logic_wren(logic_wren), .logic_gnt(logic_gnt),
    .logic_rvalid(logic_rvalid), .logic_rdata(logic_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Board RAM: registered read, one cycle latency
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  function automatic logic [1:0] pat(input int a);
    return 2'((a + 1) % 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  // Monitor: every read return must match the oldest queued expectation
  always @(negedge clock) begin
    if (logic_rvalid) begin
      if (lq.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon_logic_unexpected: got rvalid=1 expected none at %0t", $time);
      end else begin
        chk("mon_logic_rdata", 32'(logic_rdata), 32'(lq.pop_front()));
      end
    end
    if (disp_rvalid) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon_disp_unexpected: got rvalid=1 expected none at %0t", $time);
      end else begin
        chk("mon_disp_rdata", 32'(disp_rdata), 32'(dq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {init_gnt, logic_gnt, disp_gnt}, 0);
    chk({tag, "_rvalid"}, {logic_rvalid, disp_rvalid}, 0);
    chk({tag, "_rdata"}, {logic_rdata, disp_rdata}, 0);
    chk({tag, "_ram"}, {ram_addr, ram_data, ram_wren}, 0);
  endtask

  initial begin
    int errs;
    reset = 1'b0;
    init_req = 0; init_wren = 0; init_addr = 0; init_data = 0;
    logic_req = 0; logic_wren = 0; logic_addr = 0; logic_wdata = 0;
    disp_req = 0; disp_addr = 0;
    repeat (3) @(posedge clock);
    #1;
    mid();
    chk_reset_outputs("reset");
    nxt(); reset = 1'b1; mid();

    // Init sweep over all 100 cells
    nxt(); init_req = 1; init_addr = 0; init_data = pat(0); init_wren = 1; mid();
    chk("init_gnt_latency", init_gnt, 0);
    errs = 0;
    for (int a = 0; a < 100; a++) begin
      nxt(); init_addr = 7'(a); init_data = pat(a); mid();
      if (!(init_gnt && ram_wren && ram_addr == 7'(a) && ram_data == pat(a)
            && !logic_rvalid && !disp_rvalid)) errs++;
    end
    chk("init_sweep_errs", errs, 0);
    nxt(); init_req = 0; init_wren = 0; mid();
    chk("init_noreq_wren", {init_gnt, ram_wren}, 2'b10);
    nxt(); mid();
    errs = 0;
    for (int a = 0; a < 100; a++) if (mem[a] != pat(a)) errs++;
    chk("init_landed_errs", errs, 0);

    // Logic read of cell 44 (holds 01)
    nxt(); logic_req = 1; logic_addr = 44; logic_wren = 0; mid();
    chk("lrd_gnt_latency", logic_gnt, 0);
    nxt(); mid();
    chk("lrd_gnt", logic_gnt, 1);
    chk("lrd_no_early_rvalid", logic_rvalid, 0);
    lq.push_back(2'b01);
    nxt(); logic_req = 0; mid();
    chk("lrd_rvalid", logic_rvalid, 1);
    nxt(); mid();
    chk("lrd_rvalid_pulse", logic_rvalid, 0);
    chk("lrd_rdata_hold", logic_rdata, 2'b01);

    // Contention: 16 logic cycles then 1 display cycle, repeating
    nxt(); logic_req = 1; logic_addr = 10; disp_req = 1; disp_addr = 20; mid();
    chk("cont_start", {logic_gnt, disp_gnt}, 2'b00);
    for (int k = 1; k <= 34; k++) begin
      nxt(); mid();
      if (k % 17 == 0) begin
        chk("cont_gnt", {logic_gnt, disp_gnt}, 2'b01);
        dq.push_back(2'b01);
      end else begin
        chk("cont_gnt", {logic_gnt, disp_gnt}, 2'b10);
        lq.push_back(2'b11);
      end
      chk("cont_dvalid", disp_rvalid, (k > 1 && (k - 1) % 17 == 0));
      chk("cont_lvalid", logic_rvalid, (k > 1 && (k - 1) % 17 != 0));
    end
    nxt(); logic_req = 0; disp_req = 0; mid();
    chk("cont_last_dvalid", disp_rvalid, 1);
    nxt(); mid();

    // Preemption by init at logic burst cycle 5
    nxt(); logic_req = 1; logic_addr = 44; mid();
    for (int k = 1; k <= 5; k++) begin
      nxt();
      if (k == 5) begin
        init_req = 1; init_addr = 99; init_data = pat(99); init_wren = 1;
      end
      mid();
      chk("pre_lgnt", logic_gnt, 1);
      lq.push_back(2'b01);
    end
    nxt(); mid();
    chk("pre_lgnt_drop", logic_gnt, 0);
    chk("pre_igrant", init_gnt, 1);
    chk("pre_last_rvalid", logic_rvalid, 1);
    nxt(); logic_req = 0; init_req = 0; init_wren = 0; mid();
    chk("pre_no_extra_rvalid", logic_rvalid, 0);
    nxt(); mid();

    // Out-of-range write then read
    nxt(); logic_req = 1; logic_addr = 100; logic_wdata = 2'b10; logic_wren = 1; mid();
    nxt(); mid();
    chk("oor_wr", {logic_gnt, ram_addr, ram_wren}, {1'b1, 7'd100, 1'b0});
    nxt(); logic_addr = 120; logic_wren = 0; logic_wdata = 0; mid();
    chk("oor_rd_wren", ram_wren, 0);
    chk("oor_wr_no_rvalid", logic_rvalid, 0);
    lq.push_back(2'b11);
    nxt(); logic_req = 0; mid();
    chk("oor_rvalid", logic_rvalid, 1);
    nxt(); mid();
    chk("oor_rdata_hold", {logic_rvalid, logic_rdata}, 3'b011);
    chk("oor_mem100", mem[100], 2'b00);

    // Reset while a display read is in flight
    nxt(); disp_req = 1; disp_addr = 20; mid();
    nxt(); mid();
    chk("rst_dgnt", disp_gnt, 1);
    nxt(); disp_req = 0; reset = 1'b0; mid();
    chk("rst_dvalid_drop", disp_rvalid, 0);
    nxt(); mid();
    chk_reset_outputs("rst_mid");
    nxt(); reset = 1'b1; mid();
    chk("rst_after_dvalid", disp_rvalid, 0);
    nxt(); mid();

    chk("lq_drained", lq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
